// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of a word-addressed data memory.
// One request at a time: address check, read-modify-write for sub-word stores, extended loads.
module mem_access_unit #(
  parameter int          ADDR_W      = 11,
  parameter int          DEPTH_WORDS = 32,
  parameter logic [31:0] BASE_ADDR   = 32'h10010000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic              dm_ena,
  output logic              dm_wsignal,
  output logic              dm_rsignal,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  input  logic [31:0]       dm_rdata
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in S_IDLE. The response is a single-cycle resp_valid pulse with no backpressure.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_RMW  = 3'd2,
    S_WR   = 3'd3,
    S_ERR  = 3'd4,
    S_RESP = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          size_q, size_d;
  logic                signed_q, signed_d;
  logic [1:0]          lane_q, lane_d;
  logic [15:0]         wdata_q, wdata_d;
  logic                err_q, err_d;
  logic [31:0]         result_q, result_d;
  logic [ADDR_W-1:0]   dm_addr_q, dm_addr_d;
  logic [31:0]         dm_wdata_q, dm_wdata_d;

  logic [31:0] off;
  logic        addr_err;
  logic        accept;
  logic [4:0]  shamt;
  logic [31:0] rd_shift;
  logic [31:0] load_val;
  logic [31:0] merge_mask;
  logic [31:0] merge_ins;
  logic [31:0] merged;

  assign off    = req_addr - BASE_ADDR;
  assign accept = req_valid && (state_q == S_IDLE);

  always_comb begin
    addr_err = (req_addr < BASE_ADDR)
            || (off[31:2] >= 30'(DEPTH_WORDS))
            || (req_size == 2'b11)
            || ((req_size == 2'b01) && req_addr[0])
            || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
  end

  // Lane extraction for loads and lane insertion for sub-word stores.
  assign shamt    = {lane_q, 3'b000};
  assign rd_shift = dm_rdata >> shamt;

  always_comb begin
    load_val = dm_rdata;
    case (size_q)
      2'b00:   load_val = {{24{signed_q & rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   load_val = {{16{signed_q & rd_shift[15]}}, rd_shift[15:0]};
      default: load_val = dm_rdata;
    endcase
  end

  assign merge_mask = ((size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << shamt;
  assign merge_ins  = {16'h0000, wdata_q} << shamt;
  assign merged     = (dm_rdata & ~merge_mask) | (merge_ins & merge_mask);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      size_q     <= 2'b00;
      signed_q   <= 1'b0;
      lane_q     <= 2'b00;
      wdata_q    <= 16'h0000;
      err_q      <= 1'b0;
      result_q   <= 32'h0000_0000;
      dm_addr_q  <= '0;
      dm_wdata_q <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      signed_q   <= signed_d;
      lane_q     <= lane_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      result_q   <= result_d;
      dm_addr_q  <= dm_addr_d;
      dm_wdata_q <= dm_wdata_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (addr_err)                state_d = S_ERR;
          else if (!req_we)            state_d = S_RD;
          else if (req_size == 2'b10)  state_d = S_WR;
          else                         state_d = S_RMW;
        end
      end
      S_RD:    state_d = S_RESP;
      S_RMW:   state_d = S_WR;
      S_WR:    state_d = S_RESP;
      S_ERR:   state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath registers; dm_addr/dm_wdata only change when a new access needs them.
  always_comb begin
    size_d     = size_q;
    signed_d   = signed_q;
    lane_d     = lane_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    result_d   = result_q;
    dm_addr_d  = dm_addr_q;
    dm_wdata_d = dm_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          size_d   = req_size;
          signed_d = req_signed;
          // off[1:0] + BASE[1:0] is always req_addr[1:0] modulo 4.
          lane_d   = off[1:0] + BASE_ADDR[1:0];
          wdata_d  = req_wdata[15:0];
          err_d    = addr_err;
          result_d = 32'h0000_0000;
          if (!addr_err) begin
            dm_addr_d = off[ADDR_W+1:2];
            if (req_we && (req_size == 2'b10)) dm_wdata_d = req_wdata;
          end
        end
      end
      S_RD:    result_d   = load_val;
      S_RMW:   dm_wdata_d = merged;
      default: ;
    endcase
  end

  // Outputs decode from the current state only, so an async reset drops the strobes at once.
  always_comb begin
    req_ready  = (state_q == S_IDLE);
    dm_ena     = (state_q == S_RD) || (state_q == S_RMW) || (state_q == S_WR);
    dm_rsignal = (state_q == S_RD) || (state_q == S_RMW);
    dm_wsignal = (state_q == S_WR);
    resp_valid = (state_q == S_RESP);
    resp_err   = (state_q == S_RESP) && err_q;
    resp_rdata = (state_q == S_RESP) ? result_q : 32'h0000_0000;
    dm_addr    = dm_addr_q;
    dm_wdata   = dm_wdata_q;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-array memory model, response scoreboard, directed and random traffic.
module tb_mem_access_unit;
  localparam logic [31:0] BASE  = 32'h10010000;
  localparam int          DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        dm_ena;
  logic        dm_wsignal;
  logic        dm_rsignal;
  logic [10:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;

  mem_access_unit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .dm_ena(dm_ena), .dm_wsignal(dm_wsignal), .dm_rsignal(dm_rsignal),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
  );

  // Clock / reset
  always #5 clk = ~clk;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Data memory attached to the DUT
  logic [31:0] mem [0:DEPTH-1];
  assign dm_rdata = (dm_addr < 11'(DEPTH)) ? mem[dm_addr[4:0]] : 32'h0;
  always @(posedge clk) begin
    if (dm_ena && dm_wsignal && (dm_addr < 11'(DEPTH))) mem[dm_addr[4:0]] <= dm_wdata;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: byte-addressed little-endian memory, applied when a store completes.
  logic [7:0] ref_bytes [0:4*DEPTH-1];

  typedef struct {
    int unsigned due;
    logic        err;
    logic [31:0] rdata;
    logic        we;
    int          n;
    int unsigned off;
    logic [31:0] wdata;
    int          ena;
    int          wr;
    int          rd;
    logic [10:0] idx;
  } exp_t;

  exp_t exp_q[$];

  function automatic exp_t model_req(input logic we, input logic [1:0] sz, input logic sg,
                                     input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    int unsigned off;
    int n;
    off = a - BASE;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    e.err = (a < BASE) || (off / 4 >= DEPTH) || (sz == 2'd3)
         || ((sz == 2'd1) && a[0]) || ((sz == 2'd2) && (a[1:0] != 2'd0));
    e.we = we; e.n = n; e.off = off; e.wdata = wd; e.idx = 11'(off / 4);
    e.rdata = 32'h0;
    if (!e.err && !we) begin
      for (int i = 0; i < n; i++) e.rdata = e.rdata | (32'(ref_bytes[off + i]) << (8 * i));
      if (sg && n < 4 && e.rdata[8 * n - 1]) e.rdata = e.rdata | (32'hFFFFFFFF << (8 * n));
    end
    e.due = 0;
    e.ena = e.err ? 0 : (we && n < 4) ? 2 : 1;
    e.wr  = (!e.err && we) ? 1 : 0;
    e.rd  = e.err ? 0 : (!we || n < 4) ? 1 : 0;
    return e;
  endfunction

  int          ena_cnt = 0, wr_cnt = 0, rd_cnt = 0;
  int          resp_cnt = 0;
  logic [31:0] last_rdata = 32'h0;
  logic        last_err = 1'b0;

  // Compare process: every cycle, outputs against the model.
  always @(negedge clk) begin
    exp_t e;
    logic model_ready;
    logic [31:0] b;
    if (!rst_n) begin
      exp_q.delete();
      chk("reset_resp_valid", 32'(resp_valid), 32'd0);
      chk("reset_req_ready", 32'(req_ready), 32'd1);
      chk("reset_dm_strobes", {29'd0, dm_ena, dm_wsignal, dm_rsignal}, 32'd0);
    end else begin
      model_ready = (exp_q.size() == 0);
      if (dm_ena) begin
        ena_cnt++;
        if (dm_wsignal) wr_cnt++;
        if (dm_rsignal) rd_cnt++;
        if (exp_q.size() == 0) chk("stray_dm_ena", 32'(dm_ena), 32'd0);
        else chk("dm_addr", 32'(dm_addr), 32'(exp_q[0].idx));
      end
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        chk("resp_valid", 32'(resp_valid), 32'd1);
        chk("resp_err", 32'(resp_err), 32'(e.err));
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("dm_ena_cycles", 32'(ena_cnt), 32'(e.ena));
        chk("dm_write_cycles", 32'(wr_cnt), 32'(e.wr));
        chk("dm_read_cycles", 32'(rd_cnt), 32'(e.rd));
        if (e.we && !e.err) begin
          for (int i = 0; i < e.n; i++) begin
            b = e.wdata >> (8 * i);
            ref_bytes[e.off + i] = b[7:0];
          end
        end
        resp_cnt++;
        last_rdata = resp_rdata;
        last_err = resp_err;
      end else begin
        chk("resp_valid_quiet", 32'(resp_valid), 32'd0);
      end
      chk("req_ready", 32'(req_ready), 32'(model_ready));
      if (req_valid && model_ready) begin
        e = model_req(req_we, req_size, req_signed, req_addr, req_wdata);
        e.due = cyc + ((!e.err && e.we && e.n < 4) ? 3 : 2);
        exp_q.push_back(e);
        ena_cnt = 0; wr_cnt = 0; rd_cnt = 0;
      end
    end
  end

  // Driver tasks (called at posedge + #1)
  task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd);
    logic done;
    done = 1'b0;
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (req_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got no accept expected accept (addr %h)", a);
      req_valid = 1'b0;
    end
  endtask

  task automatic wait_resp(input int start);
    int n;
    n = 0;
    while (resp_cnt <= start && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (resp_cnt <= start) begin
      errors++;
      $display("FAIL resp_timeout: got %0d responses expected more than %0d", resp_cnt, start);
    end
  endtask

  task automatic txn(input logic we, input logic [1:0] sz, input logic sg,
                     input logic [31:0] a, input logic [31:0] wd);
    int start;
    start = resp_cnt;
    issue(we, sz, sg, a, wd);
    req_valid = 1'b0;
    wait_resp(start);
  endtask

  task automatic drain();
    int n;
    n = 0;
    req_valid = 1'b0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  logic [31:0] err_addr [5];
  logic [1:0]  err_size [5];

  initial begin
    int start;
    logic [31:0] a;
    logic [1:0]  sz;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
    for (int i = 0; i < 4 * DEPTH; i++) ref_bytes[i] = 8'h0;
    err_addr = '{32'h10010006, 32'h10010001, 32'h10010000, 32'h10010080, 32'h1000FFFC};
    err_size = '{2'd2, 2'd1, 2'd3, 2'd2, 2'd2};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_dm_addr", 32'(dm_addr), 32'd0);
    chk("reset_dm_wdata", dm_wdata, 32'd0);
    chk("reset_resp_rdata", resp_rdata, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Word store then load
    txn(1'b1, 2'd2, 1'b0, 32'h10010008, 32'hDEADBEEF);
    chk("word_store_mem", mem[2], 32'hDEADBEEF);
    txn(1'b0, 2'd2, 1'b0, 32'h10010008, 32'h0);
    chk("word_load_lit", last_rdata, 32'hDEADBEEF);
    chk("word_load_err", 32'(last_err), 32'd0);

    // Sub-word merge
    txn(1'b1, 2'd2, 1'b0, 32'h10010000, 32'h11223344);
    txn(1'b1, 2'd0, 1'b0, 32'h10010002, 32'h000000AB);
    chk("byte_merge_mem", mem[0], 32'h11AB3344);
    txn(1'b0, 2'd0, 1'b1, 32'h10010002, 32'h0);
    chk("byte_load_signed", last_rdata, 32'hFFFFFFAB);
    txn(1'b0, 2'd0, 1'b0, 32'h10010002, 32'h0);
    chk("byte_load_unsigned", last_rdata, 32'h000000AB);

    // Halfword extension
    txn(1'b1, 2'd2, 1'b0, 32'h10010004, 32'h80017FFE);
    txn(1'b0, 2'd1, 1'b1, 32'h10010006, 32'h0);
    chk("half_load_hi_signed", last_rdata, 32'hFFFF8001);
    txn(1'b0, 2'd1, 1'b1, 32'h10010004, 32'h0);
    chk("half_load_lo_signed", last_rdata, 32'h00007FFE);

    // Error cases
    for (int i = 0; i < 5; i++) begin
      txn(1'b0, err_size[i], 1'b0, err_addr[i], 32'h0);
      chk("err_flag", 32'(last_err), 32'd1);
      chk("err_rdata", last_rdata, 32'd0);
    end

    // Reset during the write cycle of a word store to index 3
    issue(1'b1, 2'd2, 1'b0, 32'h1001000C, 32'h5555AAAA);
    req_valid = 1'b0;
    chk("wr_strobe_before_reset", 32'(dm_wsignal), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("wr_strobe_async_drop", 32'(dm_wsignal), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("ready_after_reset", 32'(req_ready), 32'd1);
    chk("aborted_write_mem", mem[3], 32'h0);
    start = resp_cnt;
    repeat (4) @(posedge clk);
    #1;
    chk("no_resp_after_abort", 32'(resp_cnt), 32'(start));

    // Back-to-back loads with req_valid held high
    start = resp_cnt;
    issue(1'b0, 2'd2, 1'b0, 32'h10010000, 32'h0);
    issue(1'b0, 2'd0, 1'b1, 32'h10010003, 32'h0);
    issue(1'b0, 2'd1, 1'b0, 32'h10010008, 32'h0);
    drain();
    chk("b2b_resp_count", 32'(resp_cnt - start), 32'd3);
    chk("b2b_last_rdata", last_rdata, 32'h0000BEEF);

    // Randomized traffic
    for (int t = 0; t < 400; t++) begin
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 19) == 0) a = BASE - $urandom_range(1, 8);
      else a = BASE + $urandom_range(0, 4 * DEPTH + 7);
      if ($urandom_range(0, 1) == 1 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        req_valid = 1'b0;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store sequencer directly upstream of the data memory; the only driver of its ena/wsignal/rsignal/addr/wdata pins and the only consumer of its rdata.
- Accepts one byte/half/word request at a time from the CPU memory stage over a valid/ready handshake.
- Translates the byte address to a word index and range/alignment checks it.
- Performs read-modify-write for sub-word stores and sign/zero extension for loads.
- Returns a one-cycle response pulse.

Parameters:
ADDR_W, 11, width of data-memory word index (dm_addr)
DEPTH_WORDS, 32, number of implemented words; indices >= DEPTH_WORDS are out of range
BASE_ADDR, 32'h10010000, byte address mapped to word index 0

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request this cycle
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
req_signed  in  1  loads only: 1 sign-extend, 0 zero-extend
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified for sub-word stores
resp_valid  out  1  one-cycle completion pulse
resp_err  out  1  valid with resp_valid: misaligned, illegal size or out of range
resp_rdata  out  32  load result, valid with resp_valid; 0 for stores and errors
dm_ena  out  1  data-memory enable
dm_wsignal  out  1  data-memory write strobe
dm_rsignal  out  1  data-memory read strobe
dm_addr  out  ADDR_W  data-memory word index
dm_wdata  out  32  data-memory write data
dm_rdata  in  32  data-memory combinational read data

Behaviour:
- Reset (async, rst_n=0): state IDLE.
  - All outputs 0 except req_ready=1.
  - Latched request and result registers cleared.
  - Reset mid-operation drops dm_wsignal immediately, so a pending write is aborted; no response is issued for the in-flight request.
- Handshake: transfer when req_valid && req_ready. req_ready=1 only in IDLE. Request fields sampled on the accept edge only.
- Address check, combinational on req_addr at accept:
  - off = req_addr - BASE_ADDR (32-bit).
  - Error if req_addr < BASE_ADDR, if off[31:2] >= DEPTH_WORDS, if req_size==11, if half and addr[0]=1, or if word and addr[1:0]!=0.
  - Word index = off[ADDR_W+1:2]. Byte lane = addr[1:0], little-endian: lane 0 = bits[7:0].
- States:
  - IDLE: on accept, go to ERR if error; else load→RD; word store→WR; byte/half store→RMW.
  - RD: dm_ena=1, dm_rsignal=1, dm_addr=index. At the edge, extract lane(s) from dm_rdata, extend per req_signed, register as result. →RESP.
  - RMW: dm_ena=1, dm_rsignal=1. At the edge, merge req_wdata[7:0] or [15:0] into the lane(s) of dm_rdata and register the merged word. →WR.
  - WR: dm_ena=1, dm_wsignal=1, dm_rsignal=0, dm_wdata = merged word (or req_wdata for word store). The memory writes on this edge. →RESP.
  - ERR: no dm_* activity. →RESP with error flag set.
  - RESP: resp_valid=1 for exactly one cycle; resp_err and resp_rdata driven from registers. →IDLE.
- dm_ena/dm_wsignal/dm_rsignal are 0 in IDLE, ERR and RESP. dm_addr and dm_wdata hold the last values (0 after reset).
- Latency (accept edge to resp_valid high):
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
  - error: 2 cycles
- Throughput: the next request can be accepted the cycle after RESP.
- The response has no backpressure; the consumer must take it on the pulse.
- Halfword lanes: addr[1]=0 → bits[15:0], addr[1]=1 → bits[31:16].

Test Plan:
- Word store then load: store 0xDEADBEEF to 0x10010008, then load word from 0x10010008. Require:
  - dm_addr=2 with dm_wsignal high for one cycle.
  - The load returns 0xDEADBEEF, resp_err=0.
  - 2-cycle latency each.
- Sub-word merge: with word at 0x10010000 = 0x11223344, store byte 0xAB to 0x10010002. Require:
  - One RMW read cycle, then a write of 0x11AB3344.
  - Signed byte load from 0x10010002 = 0xFFFFFFAB; unsigned load = 0x000000AB.
- Halfword extension: with word = 0x8001_7FFE, signed half load from offset 2 = 0xFFFF8001, from offset 0 = 0x00007FFE.
- Errors: each of the following gives resp_err=1, resp_rdata=0, no dm_ena pulse, latency 2:
  - word load from 0x10010006
  - half load from 0x10010001
  - size 11
  - 0x10010080 (index 32)
  - 0x1000FFFC
- Reset mid-op: assert rst_n=0 during WR of a store of 0x5555AAAA to index 3. Require:
  - dm_wsignal falls asynchronously; index 3 unchanged (still the previous 0x00000000).
  - No resp_valid; req_ready=1 after release.
- Back-to-back: hold req_valid high with 3 queued loads. Require req_ready high only in IDLE, exactly one resp_valid per request, in order, with no request lost or duplicated.
